sprite_mover: RTL

Parametrised successor to the single-ship drawer. Owns one rectangular sprite's position, applies left/right/up/down movement with clamping once per frame tick, then streams an erase pass at the old position and a draw pass at the new one to the VGA adapter, one pixel per cycle. Sprite size, screen bounds, step size, colours and a per-pixel bitmap mask are parameters, so the player ship, invaders and bullets all use the same block.

---
 rtl/sprite_pkg.sv | 39 +++
 rtl/sprite_scan.sv | 53 +++++
 rtl/sprite_mover.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/sprite_pkg.sv
// Shared types and helpers for the sprite drawing blocks: coordinate widths,
// colour type, FSM state encoding and the clamped position step.
package sprite_pkg;

    localparam int XW = 9;
    localparam int YW = 8;

    typedef logic [2:0] colour_t;

    localparam colour_t BLACK = 3'b000;
    localparam colour_t WHITE = 3'b111;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ERASE = 3'd1,
        MOVE  = 3'd2,
        DRAW  = 3'd3,
        DONE  = 3'd4
    } state_t;

    // One clamped step on an axis; an extra top bit keeps pos+step from wrapping.
    function automatic logic [XW:0] step_clamp(
        input logic [XW:0] pos,
        input logic [XW:0] step,
        input logic [XW:0] lim,
        input logic        dec,
        input logic        inc
    );
        logic [XW:0] sum;
        sum        = pos + step;
        step_clamp = pos;
        if (dec && !inc) begin
            step_clamp = (pos < step) ? '0 : pos - step;
        end else if (inc && !dec) begin
            step_clamp = (sum > lim) ? lim : sum;
        end
    endfunction

endpackage

// File: rtl/sprite_scan.sv
// Row-major raster counter over an SPR_W x SPR_H sprite: column, row and
// flat bitmap index, with a flag on the final pixel.
module sprite_scan #(
    parameter int SPR_W = 10,
    parameter int SPR_H = 4
) (
    input  logic                                                  clk,
    input  logic                                                  reset,
    input  logic                                                  clear,
    input  logic                                                  step,
    output logic [((SPR_W > 1) ? $clog2(SPR_W) : 1)-1:0]          col,
    output logic [((SPR_H > 1) ? $clog2(SPR_H) : 1)-1:0]          row,
    output logic [((SPR_W*SPR_H > 1) ? $clog2(SPR_W*SPR_H) : 1)-1:0] idx,
    output logic                                                  last
);

    localparam int N  = SPR_W * SPR_H;
    localparam int CW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int RW = (SPR_H > 1) ? $clog2(SPR_H) : 1;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [CW-1:0] col_reg;
    logic [RW-1:0] row_reg;
    logic [IW-1:0] idx_reg;

    assign last = (idx_reg == IW'(N - 1));
    assign col  = col_reg;
    assign row  = row_reg;
    assign idx  = idx_reg;

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            col_reg <= '0;
            row_reg <= '0;
            idx_reg <= '0;
        end else if (step) begin
            if (last) begin
                col_reg <= '0;
                row_reg <= '0;
                idx_reg <= '0;
            end else begin
                idx_reg <= idx_reg + 1'b1;
                if (col_reg == CW'(SPR_W - 1)) begin
                    col_reg <= '0;
                    row_reg <= row_reg + 1'b1;
                end else begin
                    col_reg <= col_reg + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/sprite_mover.sv
// One rectangular sprite: on each frame tick erase it at the old position,
// step it with clamping, then draw it at the new position, one pixel per cycle.
module sprite_mover
    import sprite_pkg::*;
#(
    parameter int                     SPR_W  = 10,
    parameter int                     SPR_H  = 4,
    parameter int                     SCR_W  = 320,
    parameter int                     SCR_H  = 240,
    parameter int                     X_INIT = 160,
    parameter int                     Y_INIT = 200,
    parameter int                     STEP   = 1,
    parameter colour_t                FG     = 3'b111,
    parameter colour_t                BG     = 3'b000,
    parameter logic [SPR_W*SPR_H-1:0] MASK   = '1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          tick,
    input  logic          left,
    input  logic          right,
    input  logic          up,
    input  logic          down,
    output logic          busy,
    output logic          done,
    output logic          plot,
    output logic [XW-1:0] x_out,
    output logic [YW-1:0] y_out,
    output logic [2:0]    colour,
    output logic [XW-1:0] pos_x,
    output logic [YW-1:0] pos_y
);

    localparam int N  = SPR_W * SPR_H;
    localparam int CW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int RW = (SPR_H > 1) ? $clog2(SPR_H) : 1;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    state_t        state_reg, state_next;
    logic [XW-1:0] pos_x_reg;
    logic [YW-1:0] pos_y_reg;
    logic          left_reg, right_reg, up_reg, down_reg;
    logic          flush_reg;

    logic          plot_reg;
    logic [XW-1:0] x_out_reg;
    logic [YW-1:0] y_out_reg;
    colour_t       colour_reg;

    logic          scan_clear, scan_step, scan_last, emit;
    colour_t       pix_colour;
    logic [CW-1:0] scan_col;
    logic [RW-1:0] scan_row;
    logic [IW-1:0] scan_idx;

    sprite_scan #(
        .SPR_W (SPR_W),
        .SPR_H (SPR_H)
    ) u_scan (
        .clk   (clk),
        .reset (reset),
        .clear (scan_clear),
        .step  (scan_step),
        .col   (scan_col),
        .row   (scan_row),
        .idx   (scan_idx),
        .last  (scan_last)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // DRAW holds one extra cycle (flush_reg) so done lands after the last pixel register.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (tick) state_next = ERASE;
            ERASE:   if (scan_last) state_next = MOVE;
            MOVE:    state_next = DRAW;
            DRAW:    if (flush_reg) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy       = (state_reg != IDLE);
        done       = (state_reg == DONE);
        scan_clear = (state_reg == IDLE) || (state_reg == MOVE);
        emit       = (state_reg == ERASE) || ((state_reg == DRAW) && !flush_reg);
        scan_step  = emit;
        pix_colour = (state_reg == DRAW) ? FG : BG;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            flush_reg <= 1'b0;
        end else begin
            flush_reg <= (state_reg == DRAW) && !flush_reg && scan_last;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            left_reg  <= 1'b0;
            right_reg <= 1'b0;
            up_reg    <= 1'b0;
            down_reg  <= 1'b0;
        end else if ((state_reg == IDLE) && tick) begin
            left_reg  <= left;
            right_reg <= right;
            up_reg    <= up;
            down_reg  <= down;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pos_x_reg <= XW'(X_INIT);
            pos_y_reg <= YW'(Y_INIT);
        end else if (state_reg == MOVE) begin
            pos_x_reg <= XW'(step_clamp({1'b0, pos_x_reg}, (XW+1)'(STEP),
                                        (XW+1)'(SCR_W - SPR_W), left_reg, right_reg));
            pos_y_reg <= YW'(step_clamp({{(XW-YW+1){1'b0}}, pos_y_reg}, (XW+1)'(STEP),
                                        (XW+1)'(SCR_H - SPR_H), up_reg, down_reg));
        end
    end

    // Masked-off pixels still take their cycle; only the strobe is suppressed.
    always_ff @(posedge clk) begin
        if (!reset) begin
            plot_reg   <= 1'b0;
            x_out_reg  <= XW'(X_INIT);
            y_out_reg  <= YW'(Y_INIT);
            colour_reg <= BG;
        end else if (emit) begin
            plot_reg   <= MASK[scan_idx];
            x_out_reg  <= pos_x_reg + XW'(scan_col);
            y_out_reg  <= pos_y_reg + YW'(scan_row);
            colour_reg <= pix_colour;
        end else begin
            plot_reg <= 1'b0;
        end
    end

    assign plot   = plot_reg;
    assign x_out  = x_out_reg;
    assign y_out  = y_out_reg;
    assign colour = colour_reg;
    assign pos_x  = pos_x_reg;
    assign pos_y  = pos_y_reg;

endmodule
